// File: rtl/i2c_alu_sequencer.sv
// Job sequencer in front of an I2C master: reads operand A and operand B from two
// slaves, applies an 8-bit ALU op and writes the result to a third slave.
module i2c_alu_sequencer #(
  parameter logic [6:0]  P_ADDR_A  = 7'h20,
  parameter logic [6:0]  P_ADDR_B  = 7'h21,
  parameter logic [6:0]  P_ADDR_R  = 7'h22,
  parameter int unsigned P_TIMEOUT = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [1:0] i_op,
  output logic [7:0] o_addr_data,
  output logic       o_cmd,
  output logic       o_strobe,
  input  logic [7:0] i_rd_data,
  input  logic       i_done,
  input  logic       i_nack_addr,
  input  logic       i_nack_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_result,
  output logic       o_carry,
  output logic [1:0] o_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RDA_REQ,
    S_RDA_WAIT,
    S_RDB_REQ,
    S_RDB_WAIT,
    S_CALC,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_WAIT,
    S_FIN
  } state_t;

  localparam logic [9:0] TIMEOUT_LIM = 10'(P_TIMEOUT);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NACK_ADR = 2'd1;
  localparam logic [1:0] ERR_NACK_DAT = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  state_t     state, state_nxt;
  logic [1:0] op_q, op_nxt;
  logic [7:0] a_q, a_nxt;
  logic [7:0] b_q, b_nxt;
  logic [9:0] timer_q, timer_nxt;

  logic [7:0] addr_data_nxt;
  logic       cmd_nxt;
  logic       strobe_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic [7:0] result_nxt;
  logic       carry_nxt;
  logic [1:0] err_nxt;

  logic [8:0] alu_out;
  logic       in_wait;

  // Bit 8 is the add carry, or the borrow of the 9-bit subtraction.
  always_comb begin
    alu_out = 9'd0;
    case (op_q)
      2'd0:    alu_out = {1'b0, a_q} + {1'b0, b_q};
      2'd1:    alu_out = {1'b0, a_q} - {1'b0, b_q};
      2'd2:    alu_out = {1'b0, a_q & b_q};
      default: alu_out = {1'b0, a_q ^ b_q};
    endcase
  end

  assign in_wait = (state == S_RDA_WAIT) || (state == S_RDB_WAIT) || (state == S_WR_WAIT);

  always_comb begin
    state_nxt     = state;
    op_nxt        = op_q;
    a_nxt         = a_q;
    b_nxt         = b_q;
    timer_nxt     = timer_q;
    addr_data_nxt = o_addr_data;
    cmd_nxt       = o_cmd;
    strobe_nxt    = 1'b0;
    busy_nxt      = o_busy;
    done_nxt      = 1'b0;
    result_nxt    = o_result;
    carry_nxt     = o_carry;
    err_nxt       = o_err;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          op_nxt    = i_op;
          busy_nxt  = 1'b1;
          err_nxt   = ERR_NONE;
          state_nxt = S_RDA_REQ;
        end
      end

      S_RDA_REQ: begin
        strobe_nxt    = 1'b1;
        addr_data_nxt = {1'b0, P_ADDR_A};
        cmd_nxt       = 1'b1;
        timer_nxt     = 10'd0;
        state_nxt     = S_RDA_WAIT;
      end

      S_RDB_REQ: begin
        strobe_nxt    = 1'b1;
        addr_data_nxt = {1'b0, P_ADDR_B};
        cmd_nxt       = 1'b1;
        timer_nxt     = 10'd0;
        state_nxt     = S_RDB_WAIT;
      end

      S_CALC: begin
        result_nxt = alu_out[7:0];
        carry_nxt  = alu_out[8];
        state_nxt  = S_WR_ADDR;
      end

      S_WR_ADDR: begin
        strobe_nxt    = 1'b1;
        addr_data_nxt = {1'b0, P_ADDR_R};
        cmd_nxt       = 1'b0;
        state_nxt     = S_WR_DATA;
      end

      // Data strobe follows the address strobe on the very next cycle.
      S_WR_DATA: begin
        strobe_nxt    = 1'b1;
        addr_data_nxt = o_result;
        cmd_nxt       = 1'b0;
        timer_nxt     = 10'd0;
        state_nxt     = S_WR_WAIT;
      end

      S_RDA_WAIT, S_RDB_WAIT, S_WR_WAIT: begin
        if (i_nack_addr) begin
          err_nxt   = ERR_NACK_ADR;
          state_nxt = S_FIN;
        end else if (i_nack_data) begin
          err_nxt   = ERR_NACK_DAT;
          state_nxt = S_FIN;
        end else if (i_done) begin
          if (state == S_RDA_WAIT) begin
            a_nxt     = i_rd_data;
            state_nxt = S_RDB_REQ;
          end else if (state == S_RDB_WAIT) begin
            b_nxt     = i_rd_data;
            state_nxt = S_CALC;
          end else begin
            state_nxt = S_FIN;
          end
        end else if (timer_q >= TIMEOUT_LIM) begin
          err_nxt   = ERR_TIMEOUT;
          state_nxt = S_FIN;
        end else if (timer_q != 10'h3FF) begin
          timer_nxt = timer_q + 10'd1;
        end
      end

      S_FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      op_q        <= 2'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      timer_q     <= 10'd0;
      o_addr_data <= 8'd0;
      o_cmd       <= 1'b0;
      o_strobe    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_result    <= 8'd0;
      o_carry     <= 1'b0;
      o_err       <= 2'd0;
    end else begin
      state       <= state_nxt;
      op_q        <= op_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      timer_q     <= timer_nxt;
      o_addr_data <= addr_data_nxt;
      o_cmd       <= cmd_nxt;
      o_strobe    <= strobe_nxt;
      o_busy      <= busy_nxt;
      o_done      <= done_nxt;
      o_result    <= result_nxt;
      o_carry     <= carry_nxt;
      o_err       <= err_nxt;
    end
  end

endmodule

// File: doc/i2c_alu_sequencer.md
Name: i2c_alu_sequencer

Overview:
- Command sequencer directly upstream of the I2C master; drives its address/data, command and strobe inputs and consumes its read data and completion/NACK indications.
- Per job: reads operand A from one slave and operand B from another, applies an 8-bit ALU op, writes the result to a third slave.
- Reports done, error code and carry to the host; a watchdog aborts any I2C transaction that never completes.

Parameters:
- P_ADDR_A, 7'h20, 7-bit slave address holding operand A
- P_ADDR_B, 7'h21, 7-bit slave address holding operand B
- P_ADDR_R, 7'h22, 7-bit slave address receiving the result
- P_TIMEOUT, 1023, max i_clk cycles to wait for completion of one transaction (10-bit counter)

Ports:
- i_clk  input  1  system clock, same clock that drives the I2C master / SCL
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  host job request, sampled in IDLE only
- i_op  input  2  ALU op, latched with i_start: 0 add, 1 sub (A-B), 2 and, 3 xor
- o_addr_data  output  8  to master: {1'b0,addr} or write data
- o_cmd  output  1  to master: 1 read, 0 write
- o_strobe  output  1  to master: latch o_addr_data/o_cmd
- i_rd_data  input  8  from master: read data, valid when i_done=1 on a read
- i_done  input  1  from master: one-cycle pulse, transaction finished OK
- i_nack_addr  input  1  from master: one-cycle pulse, address NACK
- i_nack_data  input  1  from master: one-cycle pulse, data NACK
- o_busy  output  1  job in progress
- o_done  output  1  one-cycle pulse, job ended (success or error)
- o_result  output  8  last ALU result
- o_carry  output  1  add: carry out; sub: borrow (A<B); and/xor: 0
- o_err  output  2  0 none, 1 addr NACK, 2 data NACK, 3 timeout

Behaviour:
- Reset (async assert, sync release): state IDLE; o_strobe 0, o_cmd 0, o_addr_data 0, o_busy 0, o_done 0, o_result 0, o_carry 0, o_err 0; operand regs and timeout counter cleared.
- All outputs registered. o_strobe is high exactly one cycle per strobe.
- States: IDLE, RDA_REQ, RDA_WAIT, RDB_REQ, RDB_WAIT, CALC, WR_ADDR, WR_DATA, WR_WAIT, FIN.
- IDLE: i_start=1 -> latch i_op, o_busy<=1, o_err<=0, -> RDA_REQ. i_start ignored in all other states.
- RDA_REQ: strobe {0,P_ADDR_A}, o_cmd=1; clear timer -> RDA_WAIT.
- RDA_WAIT: i_done -> latch i_rd_data into A, -> RDB_REQ. RDB_REQ/RDB_WAIT identical with P_ADDR_B and B, then -> CALC.
- CALC (one cycle): 9-bit {carry,result} = op on zero-extended A,B; sub uses A-B mod 256 with carry = borrow. Register o_result/o_carry -> WR_ADDR.
- WR_ADDR: strobe {0,P_ADDR_R}, o_cmd=0 -> WR_DATA. WR_DATA: strobe o_result, o_cmd=0 on the very next cycle (back-to-back strobes) -> WR_WAIT.
- WR_WAIT: i_done -> FIN.
- Any *_WAIT: i_nack_addr -> o_err=1, FIN; i_nack_data -> o_err=2, FIN; timer reaches P_TIMEOUT with no response -> o_err=3, FIN. Priority same cycle: nack_addr > nack_data > done > timeout.
- Pulses from master outside a *_WAIT state are ignored.
- Error abort skips remaining reads/write; o_result/o_carry keep previous job's value if abort occurs before CALC.
- FIN: o_done=1 for one cycle, o_busy<=0 -> IDLE. New i_start accepted the cycle after FIN (o_busy low).
- Timer: 10-bit, reset on entry to each *_WAIT, saturates; counts while waiting.
- Reset mid-job: immediate return to IDLE, no o_done pulse, o_strobe forced 0.

Test Plan:
- Add: i_op=0, slave A returns 8'hF0, B returns 8'h20 -> strobes 8'h20 rd, 8'h21 rd, 8'h22 wr, 8'h10 wr; o_result=8'h10, o_carry=1, o_err=0, one o_done pulse.
- Sub borrow: i_op=1, A=8'h05, B=8'h07 -> o_result=8'hFE, o_carry=1; xor A=8'hAA,B=8'h0F -> 8'hA5, carry 0.
- NACK: i_nack_addr pulse in RDB_WAIT -> o_err=1, no write strobes, o_done pulse, o_result unchanged from prior job.
- Timeout: no response after RDA_REQ -> o_done exactly P_TIMEOUT+O(1) cycles later with o_err=3; i_nack_data and i_done same cycle -> o_err=2.
- Reset: assert i_rst_n=0 in WR_WAIT -> all outputs reset immediately; i_start during busy ignored; stray i_done in IDLE -> no state change.
